// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command wrapper.
// The RX state encoding equals the index of the packet byte being waited for.
package uart_cmd_pkg;

  localparam int PKT_BYTES = 3;
  localparam int CMD_IDX   = 0;
  localparam int HI_IDX    = 1;
  localparam int LO_IDX    = 2;

  typedef enum logic [1:0] {
    WAIT_CMD = 2'(CMD_IDX),
    WAIT_HI  = 2'(HI_IDX),
    WAIT_LO  = 2'(LO_IDX)
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_t;

endpackage

// File: rtl/resp_tx_ctrl.sv
// Response path: forwards 1-byte responses to the UART transmitter.
// A single pending slot absorbs a response that arrives while a byte is in
// flight; a newer response overwrites an older one still waiting there.
module resp_tx_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] resp,
  input  logic       send_resp,
  input  logic       tx_done,
  output logic       trmt,
  output logic [7:0] tx_data
);
  import uart_cmd_pkg::*;

  tx_state_t  state, state_nxt;
  logic       pend_full, pend_full_nxt;
  logic [7:0] pend_data, pend_data_nxt;
  logic       launch;
  logic [7:0] launch_data;

  // Next-state, pending-slot update and launch decision.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_nxt     = state;
    pend_full_nxt = pend_full;
    pend_data_nxt = pend_data;
    launch        = 1'b0;
    launch_data   = resp;
    case (state)
      TX_IDLE: begin
        if (send_resp) begin
          launch    = 1'b1;
          state_nxt = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          if (pend_full) begin
            // The older pending byte goes first; a same-cycle request refills the slot.
            launch        = 1'b1;
            launch_data   = pend_data;
            pend_full_nxt = send_resp;
            if (send_resp) pend_data_nxt = resp;
          end else if (send_resp) begin
            launch = 1'b1;
          end else begin
            state_nxt = TX_IDLE;
          end
        end else if (send_resp) begin
          pend_full_nxt = 1'b1;
          pend_data_nxt = resp;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  // State, pending slot and the registered launch pulse / held byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TX_IDLE;
      pend_full <= 1'b0;
      pend_data <= '0;
      trmt      <= 1'b0;
      tx_data   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state     <= state_nxt;
      pend_full <= pend_full_nxt;
      pend_data <= pend_data_nxt;
      trmt      <= launch;
      if (launch) tx_data <= launch_data;
    end
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// UART command wrapper: assembles 3-byte packets (cmd, data hi, data lo) from
// the RX byte stream and hands responses to the transmitter via resp_tx_ctrl.
// Optional build macro CMD_TIMEOUT_EN adds an inter-byte timeout that drops a
// partial packet; FAST_SIM shortens that timeout for simulation.
module uart_cmd_wrapper #(
  parameter int FAST_SIM = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done
);
  import uart_cmd_pkg::*;

  rx_state_t  rx_state, rx_state_nxt;
  logic [7:0] pkt_hold [PKT_BYTES-1];
  logic       take_cmd, take_hi, complete;
  logic       to_expired;

`ifdef CMD_TIMEOUT_EN
  localparam int TO_WIDTH = (FAST_SIM != 0) ? 8 : 20;
  logic [TO_WIDTH-1:0] to_cnt;

  assign to_expired = (rx_state != WAIT_CMD) && (to_cnt == '1);

  // Inter-byte timer: runs while waiting for a byte, freezes during a WAIT_LO stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (clr_rx_rdy || to_expired)
      to_cnt <= '0;
    else if (rx_state == WAIT_HI || (rx_state == WAIT_LO && !rx_rdy))
      to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_expired = 1'b0;
`endif

  // Packet assembly decisions; the last byte waits while an unread packet is held.
  always_comb begin
    rx_state_nxt = rx_state;
    clr_rx_rdy   = 1'b0;
    take_cmd     = 1'b0;
    take_hi      = 1'b0;
    complete     = 1'b0;
    case (rx_state)
      WAIT_CMD: begin
        if (rx_rdy) begin
          clr_rx_rdy   = 1'b1;
          take_cmd     = 1'b1;
          rx_state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (rx_rdy) begin
          clr_rx_rdy   = 1'b1;
          take_hi      = 1'b1;
          rx_state_nxt = WAIT_LO;
        end else if (to_expired) begin
          rx_state_nxt = WAIT_CMD;
        end
      end
      WAIT_LO: begin
        if (rx_rdy && (!cmd_rdy || clr_cmd_rdy)) begin
          clr_rx_rdy   = 1'b1;
          complete     = 1'b1;
          rx_state_nxt = WAIT_CMD;
        end else if (to_expired) begin
          rx_state_nxt = WAIT_CMD;
        end
      end
      default: rx_state_nxt = WAIT_CMD;
    endcase
  end

  // RX state, partial-byte holding registers and the published packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= WAIT_CMD;
      for (int i = 0; i < PKT_BYTES - 1; i++) pkt_hold[i] <= '0;
      cmd_rdy  <= 1'b0;
      cmd      <= '0;
      data     <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      if (take_cmd) pkt_hold[CMD_IDX] <= rx_data;
      if (take_hi)  pkt_hold[HI_IDX]  <= rx_data;
      // A completing packet wins over a same-cycle acknowledge.
      if (complete) begin
        cmd     <= pkt_hold[CMD_IDX];
        data    <= {pkt_hold[HI_IDX], rx_data};
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

  resp_tx_ctrl u_resp_tx_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .resp      (resp),
    .send_resp (send_resp),
    .tx_done   (tx_done),
    .trmt      (trmt),
    .tx_data   (tx_data)
  );

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed self-checking bench for uart_cmd_wrapper.
module tb_uart_cmd_wrapper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  uart_cmd_wrapper #(.FAST_SIM(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .data        (data),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until the DUT clears it (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    bit taken = 1'b0;
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 50 && !taken; i++) begin
      #1;
      if (clr_rx_rdy) begin
        taken = 1'b1;
        @(posedge clk);
        #1 rx_rdy = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    if (!taken) begin
      check("rx_byte_taken", clr_rx_rdy, 1);
      rx_rdy = 1'b0;
    end
  endtask

  task automatic ack_cmd();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
  endtask

  // One TX-side cycle: drive tx_done/send_resp for one edge, then sample.
  task automatic tx_cycle(input logic done, input logic send, input logic [7:0] r);
    @(negedge clk);
    tx_done   = done;
    send_resp = send;
    resp      = r;
    @(posedge clk);
    #1;
    tx_done   = 1'b0;
    send_resp = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
    resp = '0; send_resp = 1'b0; tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_cmd", cmd, 0);
    check("rst_data", data, 0);
    check("rst_trmt", trmt, 0);
    check("rst_tx_data", tx_data, 0);
    @(negedge clk) rst_n = 1'b1;

    // Basic packet, bytes spaced 10 cycles apart.
    send_byte(8'h02);
    repeat (10) @(posedge clk);
    send_byte(8'h12);
    check("p1_not_ready_early", cmd_rdy, 0);
    repeat (10) @(posedge clk);
    send_byte(8'h34);
    check("p1_cmd_rdy", cmd_rdy, 1);
    check("p1_cmd", cmd, 8'h02);
    check("p1_data", data, 16'h1234);
    ack_cmd();
    check("p1_cleared", cmd_rdy, 0);

    // Held packet stalls the third byte of the next one.
    send_byte(8'h07); send_byte(8'h08); send_byte(8'h09);
    check("p2_cmd_rdy", cmd_rdy, 1);
    send_byte(8'h05); send_byte(8'h00);
    @(negedge clk);
    rx_data = 8'hFF;
    rx_rdy  = 1'b1;
    #1 check("p3_stall_no_clr", clr_rx_rdy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("p3_stall_cmd_kept", cmd, 8'h07);
    check("p3_stall_data_kept", data, 16'h0809);
    check("p3_stall_still_no_clr", clr_rx_rdy, 0);
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    #1 check("p3_accept_with_ack", clr_rx_rdy, 1);
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
    rx_rdy      = 1'b0;
    check("p3_set_wins", cmd_rdy, 1);
    check("p3_cmd", cmd, 8'h05);
    check("p3_data", data, 16'h00FF);
    ack_cmd();
    check("p3_cleared", cmd_rdy, 0);

    // Response path.
    tx_cycle(1'b0, 1'b1, 8'hA5);
    check("tx_a5_trmt", trmt, 1);
    check("tx_a5_data", tx_data, 8'hA5);
    tx_cycle(1'b0, 1'b1, 8'h11);
    check("tx_single_pulse", trmt, 0);
    tx_cycle(1'b0, 1'b1, 8'h22);
    check("tx_busy_no_trmt", trmt, 0);
    tx_cycle(1'b1, 1'b0, 8'h00);
    check("tx_pend_trmt", trmt, 1);
    check("tx_pend_overwrite", tx_data, 8'h22);
    tx_cycle(1'b1, 1'b1, 8'h5A);
    check("tx_direct_trmt", trmt, 1);
    check("tx_direct_data", tx_data, 8'h5A);
    repeat (3) @(posedge clk);
    #1;
    check("tx_hold_trmt", trmt, 0);
    check("tx_hold_data", tx_data, 8'h5A);
    tx_cycle(1'b1, 1'b0, 8'h00);
    check("tx_to_idle_no_trmt", trmt, 0);
    tx_cycle(1'b0, 1'b1, 8'h3C);
    check("tx_idle_again_trmt", trmt, 1);
    check("tx_idle_again_data", tx_data, 8'h3C);
    tx_cycle(1'b0, 1'b1, 8'h77);
    tx_cycle(1'b1, 1'b1, 8'h88);
    check("tx_refill_trmt", trmt, 1);
    check("tx_refill_data", tx_data, 8'h77);
    tx_cycle(1'b1, 1'b0, 8'h00);
    check("tx_refilled_trmt", trmt, 1);
    check("tx_refilled_data", tx_data, 8'h88);
    tx_cycle(1'b1, 1'b0, 8'h00);
    check("tx_final_idle", trmt, 0);

    // Long gap after a command byte.
    send_byte(8'h06);
    repeat (300) @(posedge clk);
`ifdef CMD_TIMEOUT_EN
    #1;
    check("to_cmd_rdy_untouched", cmd_rdy, 0);
    check("to_cmd_untouched", cmd, 8'h05);
    send_byte(8'h03); send_byte(8'hAB); send_byte(8'hCD);
    check("to_cmd_rdy", cmd_rdy, 1);
    check("to_cmd", cmd, 8'h03);
    check("to_data", data, 16'hABCD);
`else
    send_byte(8'h03); send_byte(8'hAB);
    check("noto_cmd_rdy", cmd_rdy, 1);
    check("noto_cmd", cmd, 8'h06);
    check("noto_data", data, 16'h03AB);
`endif

    // Reset in the middle of a packet.
    send_byte(8'h0A); send_byte(8'h0B);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_rdy", cmd_rdy, 0);
    check("mid_rst_cmd", cmd, 0);
    check("mid_rst_data", data, 0);
    check("mid_rst_trmt", trmt, 0);
    check("mid_rst_tx_data", tx_data, 0);
    @(negedge clk) rst_n = 1'b1;
    send_byte(8'h0C); send_byte(8'h0D); send_byte(8'h0E);
    check("post_rst_cmd_rdy", cmd_rdy, 1);
    check("post_rst_cmd", cmd, 8'h0C);
    check("post_rst_data", data, 16'h0D0E);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
